rr_mux_4_1_arbiter: RTL

Round-robin arbiter that shares one 4:1 data multiplexer among four valid/ready requesters and drives a single registered valid/ready output channel. It computes the mux select each cycle from requester activity and a rotating priority pointer, and tags each output word with the index of its source. It sits in front of any consumer that must accept words from four producers through one narrow-mux datapath without starving any producer.

---
 rtl/rr_mux_4_1_arbiter.sv | 78 +++++++
 1 files changed

// File: rtl/rr_mux_4_1_arbiter.sv
// Round-robin 4:1 arbiter feeding one registered valid/ready output.
// Each output word is tagged with the index of the requester that supplied it.
module rr_mux_4_1_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       in_valid,
   output logic [3:0]       in_ready,
   input  logic [WIDTH-1:0] in_data0,
   input  logic [WIDTH-1:0] in_data1,
   input  logic [WIDTH-1:0] in_data2,
   input  logic [WIDTH-1:0] in_data3,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_src
);

   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [1:0]       r_out_src;
   logic [1:0]       r_ptr;

   logic             w_load_en;
   logic             w_any;
   logic             w_xfer;
   logic [1:0]       w_sel;
   logic [1:0]       w_idx;
   logic [WIDTH-1:0] w_mux;

   // Scan from the farthest slot back to ptr so the nearest request wins.
   always_comb begin
      w_load_en = !r_out_valid || out_ready;
      w_any     = |in_valid;
      w_sel     = r_ptr;
      w_idx     = r_ptr;
      for (int k = 3; k >= 0; k--) begin
         w_idx = r_ptr + 2'(k);
         if (in_valid[w_idx]) w_sel = w_idx;
      end
      w_xfer   = w_load_en && w_any && !rst;
      in_ready = w_xfer ? (4'b0001 << w_sel) : 4'b0000;
   end

   always_comb begin
      w_mux = in_data0;
      unique case (w_sel)
         2'd0: w_mux = in_data0;
         2'd1: w_mux = in_data1;
         2'd2: w_mux = in_data2;
         2'd3: w_mux = in_data3;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_src   <= 2'd0;
         r_ptr       <= 2'd0;
      end else if (w_load_en) begin
         if (w_any) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux;
            r_out_src   <= w_sel;
            r_ptr       <= w_sel + 2'd1;
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_src   = r_out_src;

endmodule
